run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer_pkg.sv | 29 ++
 rtl/run_sequencer_if.sv | 41 ++++
 rtl/seq_sat_counter.sv | 29 ++
 rtl/run_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_run_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared types and default configuration for the run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: sequencer state enum and the default parameter values used by
// run_sequencer, its counter and its interface.
package run_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_READ = 3'd4
    } seq_state_t;

    localparam int DEF_AW        = 8;
    localparam int DEF_LOAD_BASE = 0;
    localparam int DEF_LOAD_LEN  = 4;
    localparam int DEF_READ_BASE = 64;
    localparam int DEF_READ_LEN  = 2;
    localparam int DEF_TIMEOUT   = 4096;

    localparam int DATA_W        = 8;
    localparam int RUN_CYCLES_W  = 16;
    localparam int LOAD_IDX_W    = 16;
    localparam int READ_IDX_W    = 8;

endpackage

// File: rtl/run_sequencer_if.sv
// Bundles the preload stream, data-memory port, core handshake and readback stream.
// Latency: n/a (wires only).
// Backpressure: ld_* and rd_* are valid/ready; mem_* and req/done have none.
//
// Modports:
//   master - the sequencer: drives ld_ready, mem_wr_en/mem_addr/mem_wr_data,
//            req, rd_valid/rd_data; samples ld_valid/ld_data, mem_rd_data,
//            done, rd_ready.
//   slave  - the environment (loader, memory, core, reader): the opposite.
interface run_sequencer_if
    import run_seq_pkg::*;
#(
    parameter int AW = DEF_AW
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    logic              req;
    logic              done;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    modport master (
        input  ld_valid, ld_data, mem_rd_data, done, rd_ready,
        output ld_ready, mem_wr_en, mem_addr, mem_wr_data, req, rd_valid, rd_data
    );

    modport slave (
        output ld_valid, ld_data, mem_rd_data, done, rd_ready,
        input  ld_ready, mem_wr_en, mem_addr, mem_wr_data, req, rd_valid, rd_data
    );

endinterface

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the WAIT-cycle count.
// Latency: count reflects clr/en one cycle after they are sampled.
// Backpressure: none; holds its value whenever en is low.
//
// Ports: clk, reset (sync, active-high), clr (to zero, wins over en),
//        en (count up, sticks at all-ones), count.
module seq_sat_counter
    import run_seq_pkg::*;
#(
    parameter int W = RUN_CYCLES_W
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Preloads data memory, kicks the core, waits for done, then streams back results.
// Latency: a run takes 1 + LOAD_LEN beats + 1 req cycle + WAIT + READ_LEN beats.
// Backpressure: ld_ready high only in LOAD; READ holds mem_addr/rd_data while rd_ready is low.
//
// Ports: clk, reset (sync, active-high), start (one-cycle, honoured in IDLE only),
//        bus (run_sequencer_if.master: preload stream, memory port, req/done,
//        readback stream), busy (state != IDLE), timeout (sticky watchdog flag),
//        run_cycles (WAIT cycles of the last run, saturating).
// Build option: define RUN_SEQUENCER_TIMEOUT_EN to abandon WAIT after TIMEOUT
// cycles and raise timeout; otherwise WAIT is unbounded and timeout is 0.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int LOAD_BASE = DEF_LOAD_BASE,
    parameter int LOAD_LEN  = DEF_LOAD_LEN,
    parameter int READ_BASE = DEF_READ_BASE,
    parameter int READ_LEN  = DEF_READ_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    run_sequencer_if.master         bus,
    output logic                    busy,
    output logic                    timeout,
    output logic [RUN_CYCLES_W-1:0] run_cycles
);

    // Bases reduced to AW bits once so all address sums wrap modulo 2**AW.
    localparam logic [AW-1:0]         LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0]         READ_BASE_A = AW'(READ_BASE);
    localparam logic [LOAD_IDX_W-1:0] LOAD_LAST   = LOAD_IDX_W'(LOAD_LEN - 1);
    localparam logic [READ_IDX_W-1:0] READ_LAST   = READ_IDX_W'(READ_LEN - 1);

    seq_state_t              state;
    logic [LOAD_IDX_W-1:0]   idx;
    logic [READ_IDX_W-1:0]   ridx;
    logic                    done_q;

    logic                    ld_ready_q;
    logic                    req_q;
    logic                    rd_valid_q;
    logic                    busy_q;

    logic                    ld_beat;
    logic                    rd_beat;
    logic                    done_rise;
    logic                    run_clr;
    logic                    run_en;

    logic                    mem_wr_en_c;
    logic [AW-1:0]           mem_addr_c;
    logic [DATA_W-1:0]       mem_wr_data_c;
    logic [DATA_W-1:0]       rd_data_c;

    assign ld_beat   = ld_ready_q && bus.ld_valid;
    assign rd_beat   = rd_valid_q && bus.rd_ready;
    // done is a level that may still be high from the previous run; only a
    // fresh low-to-high transition counts as completion.
    assign done_rise = bus.done && !done_q;

    assign run_clr   = (state == S_IDLE) && start;
    assign run_en    = (state == S_WAIT);

    seq_sat_counter #(
        .W (RUN_CYCLES_W)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .count (run_cycles)
    );

`ifdef RUN_SEQUENCER_TIMEOUT_EN
    logic timeout_q;
    logic tmo_hit;

    // True in the WAIT cycle whose increment brings run_cycles up to TIMEOUT.
    assign tmo_hit = ({1'b0, run_cycles} + 17'd1) >= 17'(TIMEOUT);
    assign timeout = timeout_q;
`else
    // Without the watchdog WAIT never gives up, so TIMEOUT has no effect.
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT);
    assign timeout            = 1'b0;
`endif

    // Flag outputs are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            ridx       <= '0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b0;
            req_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= bus.done;
            req_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        ridx   <= '0;
                        busy_q <= 1'b1;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (LOAD_LEN > 0) begin
                            state      <= S_LOAD;
                            ld_ready_q <= 1'b1;
                        end else begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (ld_beat) begin
                        if (idx == LOAD_LAST) begin
                            idx        <= '0;
                            state      <= S_REQ;
                            ld_ready_q <= 1'b0;
                            req_q      <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (done_rise) begin
                        state      <= S_READ;
                        rd_valid_q <= 1'b1;
                    end
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
`endif
                end

                S_READ: begin
                    if (rd_beat) begin
                        if (ridx == READ_LAST) begin
                            ridx       <= '0;
                            state      <= S_IDLE;
                            rd_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            ridx <= ridx + 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    ld_ready_q <= 1'b0;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Memory port and read data follow the indices directly; ridx only moves on
    // a handshake, so a stalled reader sees a stable address and word.
    always_comb begin
        mem_wr_en_c   = 1'b0;
        mem_addr_c    = '0;
        mem_wr_data_c = '0;
        rd_data_c     = '0;
        if (state == S_LOAD) begin
            mem_addr_c = LOAD_BASE_A + AW'(idx);
            if (ld_beat) begin
                mem_wr_en_c   = 1'b1;
                mem_wr_data_c = bus.ld_data;
            end
        end else if (state == S_READ) begin
            mem_addr_c = READ_BASE_A + AW'(ridx);
            rd_data_c  = bus.mem_rd_data;
        end
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.mem_wr_en   = mem_wr_en_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wr_data = mem_wr_data_c;
    assign bus.req         = req_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_c;
    assign busy            = busy_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: preload, core handshake, readback, stalls, reset.
// Latency: checks are taken 3 time units after each rising edge.
// Backpressure: the bench plays loader, memory, core and reader.
module tb_run_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        timeout;
    logic [15:0] run_cycles;

    int errors = 0;
    int checks = 0;

    run_sequencer_if #(.AW(8)) bus ();

    run_sequencer #(
        .AW        (8),
        .LOAD_BASE (0),
        .LOAD_LEN  (4),
        .READ_BASE (64),
        .READ_LEN  (2),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .timeout    (timeout),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model with combinational read; results region preset on reset.
    logic [7:0] mem [256];
    logic [7:0] rd_log [$];
    int         rd_valid_cycles = 0;

    assign bus.mem_rd_data = mem[bus.mem_addr];

    always @(negedge clk) begin
        if (reset) begin
            mem[64] <= 8'hAA;
            mem[65] <= 8'hBB;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
        if (bus.rd_valid) rd_valid_cycles <= rd_valid_cycles + 1;
        if (bus.rd_valid && bus.rd_ready) rd_log.push_back(bus.rd_data);
    end

    logic [7:0] w1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] w2 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] w3 [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    logic [7:0] w4 [4] = '{8'h99, 8'hA1, 8'hB2, 8'hC3};

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Start a run and feed four words back to back; returns in the REQ cycle.
    task automatic start_and_load(input logic [7:0] w [4], input bit chk);
        cyc(); start = 1'b1; settle();
        cyc(); start = 1'b0; bus.ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_data = w[i];
            settle();
            if (chk) begin
                checks++;
                if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL load_wr_en[%0d]: got %b want 1", i, bus.mem_wr_en); end
                checks++;
                if (bus.mem_addr !== 8'(i)) begin errors++; $display("FAIL load_addr[%0d]: got %h want %h", i, bus.mem_addr, 8'(i)); end
                checks++;
                if (bus.mem_wr_data !== w[i]) begin errors++; $display("FAIL load_data[%0d]: got %h want %h", i, bus.mem_wr_data, w[i]); end
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL load_busy[%0d]: got %b want 1", i, busy); end
            end
            cyc();
        end
        bus.ld_valid = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.done = 1'b0; bus.rd_ready = 1'b0;
        cyc(); cyc(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.req); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", bus.ld_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_wr_en); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL reset_run_cycles: got %0d want 0", run_cycles); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        start_and_load(w1, 1'b1);
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL load_req: got %b want 1", bus.req); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL load_ld_ready_after: got %b want 0", bus.ld_ready); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL load_wr_en_after: got %b want 0", bus.mem_wr_en); end
    endtask

    // Core raises done 10 cycles after req; both result words read with no stall.
    task automatic test_run();
        int b;
        b = rd_log.size();
        bus.rd_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 10) bus.done = 1'b1;
            settle();
            if (k == 1) begin
                checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL run_req_one_cycle: got %b want 0", bus.req); end
            end
            if (k == 5) begin
                checks++; if (run_cycles !== 16'd4) begin errors++; $display("FAIL run_cycles_mid: got %0d want 4", run_cycles); end
            end
        end
        cyc(); settle();
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL run_rd_valid: got %b want 1", bus.rd_valid); end
        checks++; if (bus.mem_addr !== 8'd64) begin errors++; $display("FAIL run_addr0: got %h want 40", bus.mem_addr); end
        checks++; if (bus.rd_data !== 8'hAA) begin errors++; $display("FAIL run_data0: got %h want aa", bus.rd_data); end
        cyc(); settle();
        checks++; if (bus.rd_data !== 8'hBB) begin errors++; $display("FAIL run_data1: got %h want bb", bus.rd_data); end
        cyc(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_idle_after: got busy=%b want 0", busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL run_rd_valid_after: got %b want 0", bus.rd_valid); end
        checks++; if (run_cycles !== 16'd10) begin errors++; $display("FAIL run_cycles: got %0d want 10", run_cycles); end
        checks++; if (rd_log.size() !== b + 2) begin errors++; $display("FAIL run_word_count: got %0d want %0d", rd_log.size() - b, 2); end
        else begin
            checks++; if (rd_log[b] !== 8'hAA || rd_log[b+1] !== 8'hBB) begin errors++; $display("FAIL run_words: got %h %h want aa bb", rd_log[b], rd_log[b+1]); end
        end
        checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h11223344) begin errors++; $display("FAIL run_mem_preload: got %h%h%h%h want 11223344", mem[0], mem[1], mem[2], mem[3]); end
    endtask

    // done still high from run 1 must not complete; stray start/ld_valid ignored;
    // reader stalls three cycles on the second word.
    task automatic test_stall_done_held();
        int b;
        b = rd_log.size();
        bus.rd_ready = 1'b0;
        start_and_load(w2, 1'b0);
        bus.ld_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            start = (k == 2);
            if (k == 4) bus.ld_valid = 1'b0;
            if (k == 4 || k == 5) bus.done = 1'b0;
            if (k == 6) bus.done = 1'b1;
            settle();
            if (k == 3) begin
                checks++; if (bus.rd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL held_done_no_read: got rd_valid=%b busy=%b want 0 1", bus.rd_valid, busy); end
                checks++; if (bus.mem_wr_en !== 1'b0 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL stray_ld_valid: got wr_en=%b ld_ready=%b want 0 0", bus.mem_wr_en, bus.ld_ready); end
                checks++; if (run_cycles !== 16'd2) begin errors++; $display("FAIL start_while_busy: got run_cycles=%0d want 2", run_cycles); end
            end
        end
        cyc(); bus.rd_ready = 1'b1; settle();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hAA) begin errors++; $display("FAIL stall_word0: got v=%b d=%h want 1 aa", bus.rd_valid, bus.rd_data); end
        for (int s = 0; s < 3; s++) begin
            cyc(); bus.rd_ready = 1'b0; settle();
            checks++; if (bus.mem_addr !== 8'd65 || bus.rd_data !== 8'hBB || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got a=%h d=%h v=%b want 41 bb 1", s, bus.mem_addr, bus.rd_data, bus.rd_valid); end
        end
        cyc(); bus.rd_ready = 1'b1; settle();
        checks++; if (bus.mem_addr !== 8'd65 || bus.rd_data !== 8'hBB) begin errors++; $display("FAIL stall_release: got a=%h d=%h want 41 bb", bus.mem_addr, bus.rd_data); end
        cyc(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle_after: got busy=%b want 0", busy); end
        checks++; if (run_cycles !== 16'd6) begin errors++; $display("FAIL stall_run_cycles: got %0d want 6", run_cycles); end
        checks++; if (rd_log.size() !== b + 2) begin errors++; $display("FAIL stall_word_count: got %0d want %0d", rd_log.size() - b, 2); end
        else begin
            checks++; if (rd_log[b] !== 8'hAA || rd_log[b+1] !== 8'hBB) begin errors++; $display("FAIL stall_words: got %h %h want aa bb", rd_log[b], rd_log[b+1]); end
        end
    endtask

`ifdef RUN_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        int rv;
        bus.done = 1'b0;
        rv = rd_valid_cycles;
        start_and_load(w3, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cyc(); settle();
            if (k == 16) begin
                checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got busy=%b timeout=%b want 1 0", busy, timeout); end
            end
        end
        cyc(); settle();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
        checks++; if (run_cycles !== 16'd16) begin errors++; $display("FAIL tmo_run_cycles: got %0d want 16", run_cycles); end
        cyc(); settle();
        checks++; if (rd_valid_cycles !== rv) begin errors++; $display("FAIL tmo_no_read: got %0d rd_valid cycles want 0", rd_valid_cycles - rv); end
        start = 1'b1;
        cyc(); start = 1'b0; settle();
        checks++; if (timeout !== 1'b0 || run_cycles !== 16'd0) begin errors++; $display("FAIL tmo_clear_on_start: got timeout=%b run_cycles=%0d want 0 0", timeout, run_cycles); end
        reset = 1'b1;
        cyc(); reset = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        bus.done = 1'b0;
        bus.rd_ready = 1'b1;
        start_and_load(w3, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            cyc();
            if (k == 31) bus.done = 1'b1;
            settle();
            if (k == 30) begin
                checks++; if (busy !== 1'b1 || timeout !== 1'b0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL notmo_wait: got busy=%b timeout=%b rd_valid=%b want 1 0 0", busy, timeout, bus.rd_valid); end
            end
        end
        cyc(); settle();
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL notmo_read: got %b want 1", bus.rd_valid); end
        cyc(); cyc(); settle();
        checks++; if (busy !== 1'b0 || run_cycles !== 16'd31) begin errors++; $display("FAIL notmo_end: got busy=%b run_cycles=%0d want 0 31", busy, run_cycles); end
    endtask
`endif

    task automatic test_reset_mid_load();
        cyc(); start = 1'b1; settle();
        cyc(); start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 8'h77; settle();
        cyc(); bus.ld_data = 8'h88; settle();
        cyc(); bus.ld_valid = 1'b0; reset = 1'b1; settle();
        cyc(); reset = 1'b0; settle();
        checks++; if (busy !== 1'b0 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy=%b ld_ready=%b want 0 0", busy, bus.ld_ready); end
        checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL midrst_run_cycles: got %0d want 0", run_cycles); end
        start_and_load(w4, 1'b1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %b want 0", timeout); end
        checks++; if (mem[0] !== 8'h99) begin errors++; $display("FAIL midrst_mem0: got %h want 99", mem[0]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_run();
        test_stall_done_held();
`ifdef RUN_SEQUENCER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
